audio_mix_buffer: RTL and testbench
===================================

Name: audio_mix_buffer

Overview:
Parametrised multi-voice output stage between the synthesizer processor and the audio codec controller. On each sample_clock strobe it captures NUM_CH signed voice samples and applies a per-channel gain and mute. It sums the channels with saturation and pushes the result into a DEPTH-entry FIFO. The FIFO drains one sample per out_ready cycle, so processor timing is decoupled from codec timing.

Parameters:
NUM_CH, 4, number of voice channels (>=1)
SAMPLE_W, 32, signed width of each input sample and of out_sample
GAIN_W, 8, unsigned gain width; format Q1.(GAIN_W-1), so 2^(GAIN_W-1) = unity (128 = 1.0 by default)
DEPTH, 16, FIFO entries; power of two, >=2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sample_clock  in  1  single-cycle sample strobe from audio_clocker
in_samples  in  NUM_CH*SAMPLE_W  channel k at bits [k*SAMPLE_W +: SAMPLE_W], signed
gains  in  NUM_CH*GAIN_W  channel k at bits [k*GAIN_W +: GAIN_W], unsigned
mute_mask  in  NUM_CH  bit k = 1 forces channel k contribution to 0
out_ready  in  1  codec can accept a sample (audio_out_allowed)
out_sample  out  SAMPLE_W  signed mixed sample to codec (both channels)
out_write  out  1  one-cycle write strobe to codec
fill  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a mixed sample was dropped because the FIFO was full
missed  out  1  sticky: a strobe arrived while the mixer was busy
underrun  out  1  sticky: out_ready was high with the FIFO empty after the first push
clear_flags  in  1  synchronous clear of overflow, missed and underrun
peak_level  out  SAMPLE_W  peak meter (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE; FIFO pointers=0; out_sample=0; out_write=0; fill=0; all sticky flags=0; primed=0; peak_level=0.
- FSM states: IDLE, ACCUM, SAT, PUSH.
- IDLE + sample_clock: latch in_samples, gains and mute_mask; clear the accumulator; set ch=0; go to ACCUM.
- ACCUM: once per cycle, acc += muted ? 0 : sample[ch]*gain[ch]. The product is signed SAMPLE_W+GAIN_W+1 bits with gain zero-extended. Accumulator width is SAMPLE_W+GAIN_W+1+$clog2(NUM_CH)+1. ch increments each cycle; after ch=NUM_CH-1, go to SAT.
- SAT: mix = acc >>> (GAIN_W-1), arithmetic shift, truncating toward negative infinity. Clamp mix to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. Go to PUSH.
- PUSH: write mix to the FIFO if it is not full, or if it is full and a pop occurs in the same cycle. Otherwise drop mix and set overflow. Set primed=1. Go to IDLE.
- Latency: for a strobe sampled at edge 0, fill reflects the new entry after edge NUM_CH+3.
- sample_clock seen in ACCUM, SAT or PUSH: the strobe is ignored and missed is set. The in-flight mix is unaffected.
- Drain, registered: at each edge where out_ready=1 and the FIFO is non-empty, out_sample<=head, out_write<=1 and the head is popped. Otherwise out_write<=0 and out_sample holds its value.
- Underrun: out_ready=1, FIFO empty and primed=1 sets underrun. Nothing is written.
- Simultaneous push and pop: both take effect and fill is unchanged. Push and pop on a full FIFO is accepted without overflow.
- Pointers wrap modulo DEPTH. fill ranges 0..DEPTH.
- Sticky flags set and clear_flags in the same cycle: the set wins.

Optional Feature:
Macro AUDIO_MIX_PEAK_METER_EN.
- Defined: each pushed mix updates peak_level = max(peak_level, |mix|), where |mix| saturates at 2^(SAMPLE_W-1)-1. On every sample_clock strobe accepted in IDLE, peak_level decays by peak_level >> 6, applied before the max.
- Undefined: peak_level is tied to 0 and no meter logic is synthesised.

Test Plan:
- Mix: NUM_CH=4, gains all 128, samples {1000, 2000, -500, 0}, one strobe, out_ready=1 -> out_write pulses once with out_sample=2500; strobe-to-fill latency is NUM_CH+3 edges.
- Gain/mute: gains {64, 255, 128, 128}, samples {1000, 1000, 1000, 1000}, mute_mask=4'b1000 -> out_sample=500+1992+1000=3492.
- Saturation: all samples 0x7FFFFFF0, gains 255 -> out_sample=0x7FFFFFFF. All samples 0x80000000, gains 255 -> out_sample=0x80000000.
- Overflow: out_ready=0, 17 strobes spaced 10 cycles -> fill=16, overflow=1. Then out_ready=1 -> exactly 16 writes in push order, followed by underrun=1.
- Missed strobe: two strobes 2 cycles apart -> a single mix is pushed and missed=1. clear_flags pulse -> missed=0.
- Reset mid-mix: deassert reset_n during ACCUM with fill=3 -> all outputs read 0 immediately. After release, one strobe gives fill=1 with a correct mix.

Source files
------------

// File: rtl/audio_mix_buffer.sv
`default_nettype none
// ============================================================================
// Module   : audio_mix_buffer
// Brief    : Multi-voice mixer with per-channel gain/mute, saturating sum and
//            an output FIFO that decouples processor and codec timing.
//            Optional peak meter enabled by macro AUDIO_MIX_PEAK_METER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module audio_mix_buffer #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 32,
    parameter int GAIN_W   = 8,
    parameter int DEPTH    = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sample_clock,
    input  logic [NUM_CH*SAMPLE_W-1:0]   in_samples,
    input  logic [NUM_CH*GAIN_W-1:0]     gains,
    input  logic [NUM_CH-1:0]            mute_mask,
    input  logic                         out_ready,
    output logic [SAMPLE_W-1:0]          out_sample,
    output logic                         out_write,
    output logic [$clog2(DEPTH):0]       fill,
    output logic                         overflow,
    output logic                         missed,
    output logic                         underrun,
    input  logic                         clear_flags,
    output logic [SAMPLE_W-1:0]          peak_level
);

    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(NUM_CH) + 1;
    localparam int CH_W   = $clog2(NUM_CH + 1);
    localparam int AW     = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_SAT   = 2'd2;
    localparam logic [1:0] S_PUSH  = 2'd3;

    localparam logic [CH_W-1:0] c_NCH  = CH_W'(NUM_CH);
    localparam logic [AW:0]     c_FULL = (AW + 1)'(DEPTH);
    localparam logic signed [ACC_W-1:0] c_MAX =
        {{(ACC_W - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_MIN =
        {{(ACC_W - SAMPLE_W + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

    logic [1:0]                  r_state;
    logic [CH_W-1:0]             r_ch;
    logic [NUM_CH*SAMPLE_W-1:0]  r_smp;
    logic [NUM_CH*GAIN_W-1:0]    r_gain;
    logic [NUM_CH-1:0]           r_mute;
    logic signed [ACC_W-1:0]     r_acc;
    logic [SAMPLE_W-1:0]         r_mix;
    logic                        r_primed;
    logic [SAMPLE_W-1:0]         r_mem [DEPTH];
    logic [AW-1:0]               r_wr_ptr;
    logic [AW-1:0]               r_rd_ptr;
    logic [AW:0]                 r_fill;
    logic [SAMPLE_W-1:0]         r_out_sample;
    logic                        r_out_write;
    logic                        r_overflow;
    logic                        r_missed;
    logic                        r_underrun;

    logic signed [ACC_W-1:0]     w_term;
    logic signed [ACC_W-1:0]     w_shift;
    logic signed [ACC_W-1:0]     w_clamp;
    logic                        w_pop;
    logic                        w_push_req;
    logic                        w_push;
    logic                        w_busy_strobe;

    // Gained contribution of the channel selected by r_ch (zero when muted)
    always_comb begin
        logic signed [PROD_W-1:0] v_prod;
        w_term = '0;
        v_prod = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_ch == CH_W'(k) && !r_mute[k]) begin
                v_prod = PROD_W'($signed(r_smp[k*SAMPLE_W +: SAMPLE_W]))
                       * PROD_W'($signed({1'b0, r_gain[k*GAIN_W +: GAIN_W]}));
                w_term = ACC_W'(v_prod);
            end
        end
    end

    // Remove the gain scale (floor) and clamp into the sample range
    always_comb begin
        w_shift = r_acc >>> (GAIN_W - 1);
        if (w_shift > c_MAX)
            w_clamp = c_MAX;
        else if (w_shift < c_MIN)
            w_clamp = c_MIN;
        else
            w_clamp = w_shift;
    end

    assign w_pop         = out_ready && (r_fill != '0);
    assign w_push_req    = (r_state == S_PUSH);
    assign w_push        = w_push_req && ((r_fill != c_FULL) || w_pop);
    assign w_busy_strobe = sample_clock && (r_state != S_IDLE);

    // Mixer sequencer: latch, accumulate per channel, saturate, push
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ch     <= '0;
            r_smp    <= '0;
            r_gain   <= '0;
            r_mute   <= '0;
            r_acc    <= '0;
            r_mix    <= '0;
            r_primed <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sample_clock) begin
                        r_smp   <= in_samples;
                        r_gain  <= gains;
                        r_mute  <= mute_mask;
                        r_acc   <= '0;
                        r_ch    <= '0;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    // One extra cycle after the last channel before saturating
                    if (r_ch == c_NCH) begin
                        r_state <= S_SAT;
                    end else begin
                        r_acc <= r_acc + w_term;
                        r_ch  <= r_ch + 1'b1;
                    end
                end
                S_SAT: begin
                    r_mix   <= w_clamp[SAMPLE_W-1:0];
                    r_state <= S_PUSH;
                end
                default: begin
                    r_primed <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage (no reset needed, validity tracked by pointers)
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_mix;
    end

    // FIFO pointers, occupancy and registered drain to the codec
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill       <= '0;
            r_out_sample <= '0;
            r_out_write  <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_fill <= r_fill + 1'b1;
            else if (w_pop && !w_push)
                r_fill <= r_fill - 1'b1;
            r_out_write <= w_pop;
            if (w_pop)
                r_out_sample <= r_mem[r_rd_ptr];
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_missed   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push_req && !w_push)
                r_overflow <= 1'b1;
            else if (clear_flags)
                r_overflow <= 1'b0;
            if (w_busy_strobe)
                r_missed <= 1'b1;
            else if (clear_flags)
                r_missed <= 1'b0;
            if (out_ready && (r_fill == '0) && r_primed)
                r_underrun <= 1'b1;
            else if (clear_flags)
                r_underrun <= 1'b0;
        end
    end

`ifdef AUDIO_MIX_PEAK_METER_EN
    logic [SAMPLE_W-1:0] r_peak;
    logic [SAMPLE_W-1:0] w_abs;

    // Magnitude of the pending mix, most-negative value saturates to max
    always_comb begin
        if (!r_mix[SAMPLE_W-1])
            w_abs = r_mix;
        else if (r_mix == {1'b1, {(SAMPLE_W - 1){1'b0}}})
            w_abs = {1'b0, {(SAMPLE_W - 1){1'b1}}};
        else
            w_abs = -r_mix;
    end

    // Peak hold with slow decay on every accepted strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_peak <= '0;
        else if ((r_state == S_IDLE) && sample_clock)
            r_peak <= r_peak - (r_peak >> 6);
        else if (w_push && (w_abs > r_peak))
            r_peak <= w_abs;
    end

    assign peak_level = r_peak;
`else
    assign peak_level = '0;
`endif

    assign out_sample = r_out_sample;
    assign out_write  = r_out_write;
    assign fill       = r_fill;
    assign overflow   = r_overflow;
    assign missed     = r_missed;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_mix_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_mix_buffer
// Brief    : Directed self-checking bench for audio_mix_buffer with a
//            behavioural mix model and an output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_mix_buffer;

    logic         clk;
    logic         reset_n;
    logic         sample_clock;
    logic [127:0] in_samples;
    logic [31:0]  gains;
    logic [3:0]   mute_mask;
    logic         out_ready;
    logic [31:0]  out_sample;
    logic         out_write;
    logic [4:0]   fill;
    logic         overflow;
    logic         missed;
    logic         underrun;
    logic         clear_flags;
    logic [31:0]  peak_level;

    int           checks;
    int           failures;
    int           nwrites;
    logic [31:0]  exp_q[$];
    int           smp[4];
    int           gn[4];
    logic [3:0]   msk;
    longint       pk;

    audio_mix_buffer #(
        .NUM_CH   (4),
        .SAMPLE_W (32),
        .GAIN_W   (8),
        .DEPTH    (16)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_clock (sample_clock),
        .in_samples   (in_samples),
        .gains        (gains),
        .mute_mask    (mute_mask),
        .out_ready    (out_ready),
        .out_sample   (out_sample),
        .out_write    (out_write),
        .fill         (fill),
        .overflow     (overflow),
        .missed       (missed),
        .underrun     (underrun),
        .clear_flags  (clear_flags),
        .peak_level   (peak_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Mix defined arithmetically: floor(sum(sample*gain)/128), clamped to int32
    function automatic logic [31:0] model_mix();
        longint acc;
        acc = 0;
        for (int k = 0; k < 4; k++)
            if (!msk[k]) acc += longint'(smp[k]) * longint'(gn[k]);
        acc = acc >>> 7;
        if (acc > 64'sd2147483647) acc = 64'sd2147483647;
        if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        return 32'(acc);
    endfunction

    function automatic longint model_abs(input logic [31:0] m);
        longint v;
        v = longint'($signed(m));
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        return v;
    endfunction

    // Scoreboard: every codec write must match the oldest expected mix
    always @(negedge clk) begin
        if (reset_n && out_write) begin
            nwrites++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got 0x%0h expected no write", out_sample);
            end else begin
                check("drain_sample", {32'd0, out_sample}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic strobe(input bit accepted);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) begin
            in_samples[k*32 +: 32] = smp[k];
            gains[k*8 +: 8]        = gn[k][7:0];
        end
        mute_mask    = msk;
        sample_clock = 1'b1;
        @(posedge clk);
        #1 sample_clock = 1'b0;
        if (accepted) begin
            m  = model_mix();
            pk = pk - (pk >> 6);
            if (exp_q.size() < 16) begin
                exp_q.push_back(m);
                if (model_abs(m) > pk) pk = model_abs(m);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        cycles(1);
        clear_flags = 1'b0;
    endtask

    task automatic drain_and_clear();
        out_ready = 1'b1;
        cycles(4);
        out_ready = 1'b0;
        cycles(1);
        pulse_clear();
    endtask

    task automatic set_vec(input int s0, input int s1, input int s2, input int s3,
                           input int g0, input int g1, input int g2, input int g3,
                           input logic [3:0] m);
        smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
        gn[0]  = g0; gn[1]  = g1; gn[2]  = g2; gn[3]  = g3;
        msk    = m;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        checks = 0; failures = 0; nwrites = 0; pk = 0;
        reset_n = 1'b0; sample_clock = 1'b0; in_samples = '0; gains = '0;
        mute_mask = '0; out_ready = 1'b0; clear_flags = 1'b0;
        cycles(3);
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_out_sample", 64'(out_sample), 64'd0);
        check("rst_out_write", 64'(out_write), 64'd0);
        check("rst_flags", 64'({overflow, missed, underrun}), 64'd0);
        check("rst_peak", 64'(peak_level), 64'd0);
        reset_n = 1'b1;
        cycles(2);

        // Basic mix, latency of NUM_CH+3 edges from strobe to fill
        set_vec(1000, 2000, -500, 0, 128, 128, 128, 128, 4'b0000);
        check("pin_mix_basic", 64'(model_mix()), 64'd2500);
        out_ready = 1'b1;
        w0 = nwrites;
        strobe(1'b1);
        cycles(6);
        check("latency_fill_before", 64'(fill), 64'd0);
        cycles(1);
        check("latency_fill_after", 64'(fill), 64'd1);
        cycles(4);
        check("basic_write_count", 64'(nwrites - w0), 64'd1);
        check("basic_underrun", 64'(underrun), 64'd1);
        out_ready = 1'b0;
        cycles(1);
        pulse_clear();
        check("clear_underrun", 64'(underrun), 64'd0);

        // Gain and mute
        set_vec(1000, 1000, 1000, 1000, 64, 255, 128, 128, 4'b1000);
        check("pin_mix_gain", 64'(model_mix()), 64'd3492);
        strobe(1'b1);
        cycles(9);
        check("gain_fill", 64'(fill), 64'd1);
        drain_and_clear();

        // Positive and negative saturation
        set_vec(32'h7FFFFFF0, 32'h7FFFFFF0, 32'h7FFFFFF0, 32'h7FFFFFF0, 255, 255, 255, 255, 4'b0000);
        check("pin_sat_pos", 64'(model_mix()), 64'h7FFFFFFF);
        strobe(1'b1);
        cycles(9);
        set_vec(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 255, 255, 255, 255, 4'b0000);
        check("pin_sat_neg", 64'(model_mix()), 64'h80000000);
        strobe(1'b1);
        cycles(9);
        check("sat_fill", 64'(fill), 64'd2);
        drain_and_clear();
        check("sat_drained", 64'(exp_q.size()), 64'd0);

        // Overflow: 17 strobes into a 16-deep FIFO with the codec stalled
        for (int i = 0; i < 17; i++) begin
            set_vec(i * 1000 + 1, -i * 37, i, 7 * i, 128, 128, 64, 255, 4'b0000);
            strobe(1'b1);
            cycles(9);
        end
        check("ovf_fill", 64'(fill), 64'd16);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_no_underrun", 64'(underrun), 64'd0);
        w0 = nwrites;
        out_ready = 1'b1;
        cycles(20);
        check("ovf_write_count", 64'(nwrites - w0), 64'd16);
        check("ovf_queue_empty", 64'(exp_q.size()), 64'd0);
        check("ovf_fill_empty", 64'(fill), 64'd0);
        check("ovf_underrun", 64'(underrun), 64'd1);
        out_ready = 1'b0;
        cycles(1);
        pulse_clear();
        check("ovf_cleared", 64'({overflow, missed, underrun}), 64'd0);

        // Missed strobe: second strobe two cycles later is ignored
        set_vec(300, -100, 50, 20, 128, 128, 128, 128, 4'b0000);
        strobe(1'b1);
        cycles(1);
        set_vec(9999, 9999, 9999, 9999, 128, 128, 128, 128, 4'b0000);
        strobe(1'b0);
        cycles(10);
        check("missed_flag", 64'(missed), 64'd1);
        check("missed_fill", 64'(fill), 64'd1);
        drain_and_clear();
        check("missed_cleared", 64'(missed), 64'd0);

        // Reset during accumulation with three entries queued
        for (int i = 0; i < 3; i++) begin
            set_vec(10 * (i + 1), 5, -3, 1, 128, 128, 128, 128, 4'b0000);
            strobe(1'b1);
            cycles(9);
        end
        check("pre_reset_fill", 64'(fill), 64'd3);
        set_vec(1, 2, 3, 4, 128, 128, 128, 128, 4'b0000);
        strobe(1'b0);
        cycles(2);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_fill", 64'(fill), 64'd0);
        check("mid_rst_out", 64'({out_sample, out_write}), 64'd0);
        check("mid_rst_flags", 64'({overflow, missed, underrun}), 64'd0);
        check("mid_rst_peak", 64'(peak_level), 64'd0);
        exp_q.delete();
        pk = 0;
        cycles(2);
        reset_n = 1'b1;
        cycles(2);
        set_vec(-7000, 1200, 256, -1, 128, 200, 255, 128, 4'b0100);
        strobe(1'b1);
        cycles(9);
        check("post_rst_fill", 64'(fill), 64'd1);
`ifdef AUDIO_MIX_PEAK_METER_EN
        check("peak_level", 64'(peak_level), 64'(pk));
`else
        check("peak_tied_zero", 64'(peak_level), 64'd0);
`endif
        drain_and_clear();
        check("post_rst_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
